pe_depacketizer: RTL
====================

# pe_depacketizer

Receive-side stage of the PE network interface, between the switch output port and the PCI return path. Accepts NoC packets addressed to this PE, which arrive in any order. Stores each payload in a reorder buffer indexed by its sequence number and streams the payloads to PCI in strict sequence order. Per frame, the order is 0..pck_num-1, wrapping. It replaces the free-running memory write of the scheduler's NoC-to-PCI path with an in-order, back-pressured stream.

## Interface
Parameters:
- X, 0, this PE's column coordinate
- Y, 0, this PE's row coordinate
- x_size, 0, width of the X coordinate field in bits
- y_size, 0, width of the Y coordinate field in bits
- pck_num, 0, packets per frame (≥2); also the reorder depth
- data_width, 0, payload width
- total_width, 0, packet width; must equal data_width + x_size + y_size + SEQ_W

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- i_data  in  total_width  packet from switch
- i_valid  in  1  packet valid
- o_ready  out  1  to switch; 0 in reset, 1 otherwise (no back-pressure to NoC)
- o_data_pci  out  data_width  in-order payload
- o_valid_pci  out  1  payload valid
- i_ready_pci  in  1  PCI accepts payload
- o_frame_done  out  1  one-cycle pulse when seq pck_num-1 is handed off
- o_dup_cnt  out  16  dropped duplicate packets (saturating)
- o_misroute_cnt  out  16  dropped wrong-destination packets (saturating)

## Operation
- Packet layout, MSB→LSB: seq[SEQ_W], dst_x[x_size], dst_y[y_size], payload[data_width]. SEQ_W = clog2(pck_num).
- Accept condition: i_valid && dst_x==X && dst_y==Y && seq<pck_num && !vbit[seq]. On accept: mem[seq]<=payload, vbit[seq]<=1.
- Drops:
  - Wrong destination or seq≥pck_num: misroute_cnt+1.
  - vbit[seq] already set: dup_cnt+1.
  - Dropped packets are never stored.
- Drain pointer rd_ptr, reset 0. Output register loads when vbit[rd_ptr] && (!o_valid_pci || i_ready_pci).
- On a load:
  - o_data_pci<=mem[rd_ptr], o_valid_pci<=1, vbit[rd_ptr]<=0.
  - rd_ptr increments, wrapping pck_num-1→0.
  - Loading seq pck_num-1 pulses o_frame_done the next cycle.
- If o_valid_pci && i_ready_pci and no load is possible, o_valid_pci<=0.
- o_data_pci is held stable while o_valid_pci && !i_ready_pci.
- Same-cycle write to a slot being drained: the duplicate check uses the pre-clear vbit, so the packet counts as a duplicate and is dropped.
- Write and drain of different slots in the same cycle: both occur.
- Counters saturate at 16'hFFFF.

## Timing
- Reset values: o_ready 0, o_valid_pci 0, o_data_pci 0, o_frame_done 0, counters 0, rd_ptr 0, all vbit 0. Mem contents are don't-care.
- Reset mid-frame discards all stored packets and any pending output immediately (asynchronous).
- Latency: a packet sampled at edge E with seq==rd_ptr and the output register free gives o_valid_pci=1 after edge E+1.
- Throughput: one payload per cycle while i_ready_pci=1 and the next slot is filled.
- Counters update at the edge after the dropped packet is sampled.

## Configuration
- PE_DEPKT_STATS_EN defined: o_dup_cnt and o_misroute_cnt counters are implemented.
- Not defined: both ports are tied to 16'd0 and no counter flops exist. Drop behaviour is unchanged.

## Structure
- Shared package pe_noc_pkg holds:
  - SEQ_W computation and field offset/width functions (payload, dst_y, dst_x, seq)
  - the CNT_W=16 constant
- Sub-module pe_reorder_mem holds the pck_num×data_width flop array plus vbit, with:
  - one write port (seq, payload, set)
  - combinational read of rd_ptr with a clear strobe
- pe_depacketizer holds the address check, rd_ptr, output register and counters.

## Test plan
All cases use pck_num=4, X=1, Y=2.
- In-order: seq 0,1,2,3 on consecutive cycles, i_ready_pci=1 → payloads out in 4 consecutive cycles, first one 2 edges after seq 0; one o_frame_done pulse.
- Reverse order: seq 3,2,1,0 → no o_valid_pci until seq 0 arrives, then 0,1,2,3 back-to-back.
- Back-pressure: i_ready_pci=0 for 5 cycles with all 4 stored → o_data_pci holds payload 0; release → 0,1,2,3 with no loss or repeats.
- Drops:
  - Packet to (0,2) → o_misroute_cnt=1, not stored.
  - seq 1 twice before its drain → o_dup_cnt=1, first payload kept.
  - Without PE_DEPKT_STATS_EN → both counters stay 0.
- Wrap: two full frames, second frame seq 2,0,3,1 → output order 0,1,2,3; two o_frame_done pulses total.
- Reset mid-frame: seq 1,2 stored, assert rst → o_valid_pci=0; after release, seq 0 alone outputs only payload 0 and rd_ptr=1.

Source files
------------

// File: rtl/pe_noc_pkg.sv
// pe_noc_pkg: shared NoC packet field geometry and counter width
// Layout MSB->LSB: seq | dst_x | dst_y | payload.
package pe_noc_pkg;
  localparam int CNT_W = 16;
  function automatic int seq_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
  function automatic int payload_lsb();
    return 0;
  endfunction
  function automatic int dst_y_lsb(input int dw);
    return dw;
  endfunction
  function automatic int dst_x_lsb(input int dw, input int ys);
    return dw + ys;
  endfunction
  function automatic int seq_lsb(input int dw, input int ys, input int xs);
    return dw + ys + xs;
  endfunction
endpackage

// File: rtl/pe_reorder_mem.sv
// pe_reorder_mem: reorder buffer (payload flops + valid bits) indexed by sequence number
// Ports: clk, rst (async high); write port wr_en_i/wr_seq_i/wr_data_i sets a slot;
// rd_ptr_i selects the combinational read rd_data_o, rd_clr_i clears that slot; vbit_o exposes all valid bits.
module pe_reorder_mem #(
  parameter int N  = 4,
  parameter int DW = 8,
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_seq_i,
  input  logic [DW-1:0] wr_data_i,
  input  logic [AW-1:0] rd_ptr_i,
  input  logic          rd_clr_i,
  output logic [DW-1:0] rd_data_o,
  output logic [N-1:0]  vbit_o
);
  logic [DW-1:0] mem_q [N];
  logic [N-1:0] vbit_q, vbit_d;
  always_comb begin
    vbit_d = vbit_q;
    if (rd_clr_i) vbit_d[rd_ptr_i] = 1'b0;
    if (wr_en_i) vbit_d[wr_seq_i] = 1'b1;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) vbit_q <= '0;
    else vbit_q <= vbit_d;
  always_ff @(posedge clk)
    if (wr_en_i) mem_q[wr_seq_i] <= wr_data_i;
  assign rd_data_o = mem_q[rd_ptr_i];
  assign vbit_o = vbit_q;
endmodule

// File: rtl/pe_depacketizer.sv
// pe_depacketizer: accepts out-of-order NoC packets for this PE and streams payloads to PCI in sequence order
// Ports: clk, rst (async high); i_data/i_valid/o_ready from switch; o_data_pci/o_valid_pci/i_ready_pci
// to PCI; o_frame_done pulses after seq pck_num-1 is loaded; o_dup_cnt/o_misroute_cnt drop counters.
// Define PE_DEPKT_STATS_EN to implement the drop counters; otherwise they read 0.
module pe_depacketizer
  import pe_noc_pkg::*;
#(
  parameter int X           = 1,
  parameter int Y           = 2,
  parameter int x_size      = 2,
  parameter int y_size      = 2,
  parameter int pck_num     = 4,
  parameter int data_width  = 8,
  parameter int total_width = data_width + x_size + y_size + seq_w(pck_num)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [total_width-1:0] i_data,
  input  logic                   i_valid,
  output logic                   o_ready,
  output logic [data_width-1:0]  o_data_pci,
  output logic                   o_valid_pci,
  input  logic                   i_ready_pci,
  output logic                   o_frame_done,
  output logic [CNT_W-1:0]       o_dup_cnt,
  output logic [CNT_W-1:0]       o_misroute_cnt
);
  localparam int SEQ_W = seq_w(pck_num);
  localparam logic [SEQ_W-1:0] LAST = SEQ_W'(pck_num - 1);
  localparam logic [SEQ_W:0] NUM = (SEQ_W + 1)'(pck_num);
  logic [SEQ_W-1:0] seq, rd_ptr_q, rd_ptr_d;
  logic [x_size-1:0] dx;
  logic [y_size-1:0] dy;
  logic [data_width-1:0] payload, rd_data, data_q;
  logic [pck_num-1:0] vbit;
  logic addr_ok, hit_full, accept, load, valid_q, ready_q, done_q;
  assign seq      = i_data[seq_lsb(data_width, y_size, x_size) +: SEQ_W];
  assign dx       = i_data[dst_x_lsb(data_width, y_size) +: x_size];
  assign dy       = i_data[dst_y_lsb(data_width) +: y_size];
  assign payload  = i_data[payload_lsb() +: data_width];
  assign addr_ok  = dx == x_size'(X) && dy == y_size'(Y) && {1'b0, seq} < NUM;
  // vbit is sampled before this cycle's drain clears it, so a packet hitting the slot being drained is a duplicate
  assign hit_full = vbit[seq];
  assign accept   = i_valid && addr_ok && !hit_full;
  assign load     = vbit[rd_ptr_q] && (!valid_q || i_ready_pci);
  assign rd_ptr_d = rd_ptr_q == LAST ? '0 : rd_ptr_q + 1'b1;
  pe_reorder_mem #(.N(pck_num), .DW(data_width), .AW(SEQ_W)) u_mem (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (accept),
    .wr_seq_i  (seq),
    .wr_data_i (payload),
    .rd_ptr_i  (rd_ptr_q),
    .rd_clr_i  (load),
    .rd_data_o (rd_data),
    .vbit_o    (vbit)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ready_q  <= 1'b0;
      rd_ptr_q <= '0;
      valid_q  <= 1'b0;
      data_q   <= '0;
      done_q   <= 1'b0;
    end else begin
      ready_q <= 1'b1;
      done_q  <= load && rd_ptr_q == LAST;
      if (load) begin
        data_q   <= rd_data;
        valid_q  <= 1'b1;
        rd_ptr_q <= rd_ptr_d;
      end else if (i_ready_pci) valid_q <= 1'b0;
    end
  assign o_ready      = ready_q;
  assign o_data_pci   = data_q;
  assign o_valid_pci  = valid_q;
  assign o_frame_done = done_q;
`ifdef PE_DEPKT_STATS_EN
  logic [CNT_W-1:0] dup_q, mis_q;
  logic dup, misr;
  assign dup  = i_valid && addr_ok && hit_full;
  assign misr = i_valid && !addr_ok;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      dup_q <= '0;
      mis_q <= '0;
    end else begin
      if (dup && !(&dup_q)) dup_q <= dup_q + 1'b1;
      if (misr && !(&mis_q)) mis_q <= mis_q + 1'b1;
    end
  assign o_dup_cnt      = dup_q;
  assign o_misroute_cnt = mis_q;
`else
  assign o_dup_cnt      = '0;
  assign o_misroute_cnt = '0;
`endif
endmodule
